// File: rtl/seven_segment_reader.sv
// Readback monitor for a multiplexed seven-segment bus: debounces each digit scan,
// decodes the glyph back to a hex nibble and assembles complete multi-digit frames.
module seven_segment_reader #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0,
    localparam int DW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [6:0]            i_seg_in,
    input  logic [DIGITS-1:0]     i_an_in,
    output logic                  o_digit_valid,
    output logic [DW-1:0]         o_digit_idx,
    output logic [3:0]            o_digit_val,
    output logic                  o_digit_err,
    output logic                  o_frame_valid,
    output logic [4*DIGITS-1:0]   o_frame_val,
    output logic [DIGITS-1:0]     o_frame_err
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ALL_CAPTURED = '1;

    typedef enum logic {S_WAIT, S_HOLD} state_t;

    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   r_smp_an, r_prev_an;
    logic [6:0]          r_smp_seg, r_prev_seg;
    logic [RW-1:0]       r_run;
    logic                w_onehot, w_same, w_accept;
    state_t              r_state, w_state_next;
    logic [3:0]          w_dec_val;
    logic                w_dec_err;
    logic [DW-1:0]       w_idx;
    logic [4*DIGITS-1:0] r_nib_store;
    logic [DIGITS-1:0]   r_err_store, r_captured, w_cap_base;
    logic                r_digit_valid, r_digit_err, r_frame_valid;
    logic [DW-1:0]       r_digit_idx;
    logic [3:0]          r_digit_val;
    logic [4*DIGITS-1:0] r_frame_val;
    logic [DIGITS-1:0]   r_frame_err;

    assign w_an  = AN_ACTIVE_LOW  ? ~i_an_in  : i_an_in;
    assign w_seg = SEG_ACTIVE_LOW ? ~i_seg_in : i_seg_in;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_smp_an   <= '0;
            r_smp_seg  <= '0;
            r_prev_an  <= '0;
            r_prev_seg <= '0;
        end else begin
            r_smp_an   <= w_an;
            r_smp_seg  <= w_seg;
            r_prev_an  <= r_smp_an;
            r_prev_seg <= r_smp_seg;
        end
    end

    assign w_onehot = (r_smp_an != '0) && ((r_smp_an & (r_smp_an - DIGITS'(1))) == '0);
    assign w_same   = (r_smp_an == r_prev_an) && (r_smp_seg == r_prev_seg);

    // Run length of the current sample, saturating; zero whenever the select is unusable.
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_onehot) begin
            r_run <= '0;
        end else if (!w_same) begin
            r_run <= RW'(1);
        end else if (r_run != RUN_MAX) begin
            r_run <= r_run + RW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_WAIT;
        else       r_state <= w_state_next;
    end

    // The w_same term keeps a sample that changed this very cycle from being accepted.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_onehot && w_same && (r_run == RUN_MAX)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_onehot || !w_same) w_state_next = S_WAIT;
            end
            default: w_state_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_dec_val = 4'h0;
        w_dec_err = 1'b0;
        case (r_smp_seg)
            7'h7E: w_dec_val = 4'h0;
            7'h30: w_dec_val = 4'h1;
            7'h6D: w_dec_val = 4'h2;
            7'h79: w_dec_val = 4'h3;
            7'h33: w_dec_val = 4'h4;
            7'h5B: w_dec_val = 4'h5;
            7'h5F: w_dec_val = 4'h6;
            7'h70: w_dec_val = 4'h7;
            7'h7F: w_dec_val = 4'h8;
            7'h7B: w_dec_val = 4'h9;
            7'h77: w_dec_val = 4'hA;
            7'h1F: w_dec_val = 4'hB;
            7'h4E: w_dec_val = 4'hC;
            7'h3D: w_dec_val = 4'hD;
            7'h4F: w_dec_val = 4'hE;
            7'h47: w_dec_val = 4'hF;
            default: w_dec_err = 1'b1;
        endcase
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_smp_an[i]) w_idx = DW'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit_valid <= 1'b0;
            r_digit_idx   <= '0;
            r_digit_val   <= '0;
            r_digit_err   <= 1'b0;
            r_nib_store   <= '0;
            r_err_store   <= '0;
        end else begin
            r_digit_valid <= w_accept;
            if (w_accept) begin
                r_digit_idx               <= w_idx;
                r_digit_val               <= w_dec_val;
                r_digit_err               <= w_dec_err;
                r_nib_store[4*w_idx +: 4] <= w_dec_val;
                r_err_store[w_idx]        <= w_dec_err;
            end
        end
    end

    // A full mask is published one cycle after the completing accept; an accept in
    // that same cycle starts the next frame.
    assign w_cap_base = (r_captured == ALL_CAPTURED) ? '0 : r_captured;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_captured    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_val   <= '0;
            r_frame_err   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            if (r_captured == ALL_CAPTURED) begin
                r_frame_valid <= 1'b1;
                r_frame_val   <= r_nib_store;
                r_frame_err   <= r_err_store;
            end
            r_captured <= w_accept ? (w_cap_base | r_smp_an) : w_cap_base;
        end
    end

    assign o_digit_valid = r_digit_valid;
    assign o_digit_idx   = r_digit_idx;
    assign o_digit_val   = r_digit_val;
    assign o_digit_err   = r_digit_err;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_val   = r_frame_val;
    assign o_frame_err   = r_frame_err;

endmodule
